// File: rtl/type_switch_sequencer.sv
// Read-request sequencer and switch_set/o_valid alignment for type_switch_module.
// Optional swap counter output is enabled with `define TYPE_SWITCH_SEQ_CNT_EN.
module type_switch_sequencer #(
    parameter int ADDR_W     = 10,
    parameter int RAM_RD_LAT = 1,
    parameter int SW_LAT     = 3,
    parameter int STRIDE_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     len,
    input  logic [1:0]          swap_mode,
    input  logic [STRIDE_W-1:0] stride_log,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                switch_set,
    output logic                o_valid,
    output logic                busy,
    output logic                done
`ifdef TYPE_SWITCH_SEQ_CNT_EN
    ,
    output logic [ADDR_W:0]     swap_cnt
`endif
);

    // Tap 0 of each chain is the element being issued this cycle; tap i is
    // the same element i cycles later. Outputs are registered, so each output
    // reads the tap one cycle before its target cycle.
    localparam int DEPTH  = RAM_RD_LAT + SW_LAT;
    localparam int SW_TAP = DEPTH - 3;
    localparam int OV_TAP = DEPTH - 1;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ELEM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        FIN   = 2'b11
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [ADDR_W:0]       len_r;
    logic [1:0]            mode_r;
    logic [STRIDE_W-1:0]   stride_r;
    logic [ADDR_W:0]       elem_r;
    logic [DEPTH-1:1]      vld_pipe_r;
    logic [SW_TAP:1]       swp_pipe_r;
    logic [DEPTH-1:0]      vld_tap_s;
    logic [SW_TAP:0]       swp_tap_s;
    logic                  start_acc_s;
    logic                  rd_en_s;
    logic [ADDR_W-1:0]     rd_addr_s;
    logic                  switch_set_s;
    logic                  o_valid_s;
    logic                  busy_s;
    logic                  done_s;

    // Shifting past the top bit yields 0, which covers stride_log > ADDR_W.
    function automatic logic swap_bit(input logic [1:0] mode,
                                      input logic [STRIDE_W-1:0] stride,
                                      input logic [ADDR_W:0] idx);
        logic [ADDR_W:0] sh;
        logic            b;
        sh = idx >> stride;
        case (mode)
            2'b01:   b = 1'b1;
            2'b10:   b = sh[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = (len == '0) ? FIN : ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (elem_r == (len_r - ELEM_ONE)) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (vld_pipe_r == '0) begin
                    next_state_s = FIN;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            FIN:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs
    always_comb begin
        start_acc_s  = (state_r == IDLE) && start;
        vld_tap_s    = {vld_pipe_r, (state_r == ISSUE)};
        swp_tap_s    = {swp_pipe_r, (state_r == ISSUE) && swap_bit(mode_r, stride_r, elem_r)};
        rd_en_s      = (next_state_s == ISSUE);
        busy_s       = (next_state_s != IDLE);
        done_s       = (next_state_s == FIN);
        switch_set_s = swp_tap_s[SW_TAP];
        o_valid_s    = vld_tap_s[OV_TAP];
        if (!rd_en_s) begin
            rd_addr_s = '0;
        end else if (state_r == IDLE) begin
            rd_addr_s = base_addr;
        end else begin
            rd_addr_s = rd_addr_r_next(rd_addr);
        end
    end

    function automatic logic [ADDR_W-1:0] rd_addr_r_next(input logic [ADDR_W-1:0] a);
        return a + ADDR_ONE;
    endfunction

    // Command fields and element counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r    <= '0;
            mode_r   <= 2'b00;
            stride_r <= '0;
            elem_r   <= '0;
        end else if (start_acc_s) begin
            len_r    <= len;
            mode_r   <= swap_mode;
            stride_r <= stride_log;
            elem_r   <= '0;
        end else if (state_r == ISSUE) begin
            elem_r   <= elem_r + ELEM_ONE;
        end else begin
            elem_r   <= elem_r;
        end
    end

    // Valid/swap alignment shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r <= '0;
            swp_pipe_r <= '0;
        end else begin
            vld_pipe_r <= vld_tap_s[DEPTH-2:0];
            swp_pipe_r <= swp_tap_s[SW_TAP-1:0];
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            switch_set <= 1'b0;
            o_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_en      <= rd_en_s;
            rd_addr    <= rd_addr_s;
            switch_set <= switch_set_s;
            o_valid    <= o_valid_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

`ifdef TYPE_SWITCH_SEQ_CNT_EN
    // Swap counter: counts cycles with switch_set high for the current command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_cnt <= '0;
        end else if (start_acc_s) begin
            swap_cnt <= '0;
        end else if (switch_set) begin
            swap_cnt <= swap_cnt + ELEM_ONE;
        end else begin
            swap_cnt <= swap_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_type_switch_sequencer.sv
// Self-checking bench for type_switch_sequencer: timing-formula model plus directed literal checks.
module tb_type_switch_sequencer;

    localparam int AW = 10, RL = 1, SL = 3, SWW = 4;
    localparam int SW_OFF = RL + SL - 2;
    localparam int OV_OFF = RL + SL;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [AW:0]    len = '0;
    logic [1:0]     swap_mode = 2'b00;
    logic [SWW-1:0] stride_log = '0;
    logic           rd_en, switch_set, o_valid, busy, done;
    logic [AW-1:0]  rd_addr;
`ifdef TYPE_SWITCH_SEQ_CNT_EN
    logic [AW:0]    swap_cnt;
`endif

    type_switch_sequencer #(.ADDR_W(AW), .RAM_RD_LAT(RL), .SW_LAT(SL), .STRIDE_W(SWW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .swap_mode(swap_mode), .stride_log(stride_log), .rd_en(rd_en), .rd_addr(rd_addr),
        .switch_set(switch_set), .o_valid(o_valid), .busy(busy), .done(done)
`ifdef TYPE_SWITCH_SEQ_CNT_EN
        , .swap_cnt(swap_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model of the active command
    bit m_act = 1'b0;
    int m_c0 = 0, m_base = 0, m_len = 0, m_mode = 0, m_stride = 0, m_swaps = 0, done_count = 0;
    int obs_addr[64];
    bit obs_en[64], obs_sw[64], obs_ov[64], obs_done[64], obs_busy[64];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit swapbit(input int k, input int mode, input int stride);
        if (mode == 1) return 1'b1;
        if (mode == 2 && stride <= AW) return bit'((k >> stride) & 1);
        return 1'b0;
    endfunction

    function automatic int done_rel(input int l);
        return (l == 0) ? 0 : l + RL + SL;
    endfunction

    // per-cycle compare against the model, then model update on start
    initial begin
        forever begin : cmp
            int rel, k, s;
            bit e_en, e_sw, e_ov, e_done, e_busy;
            int e_addr;
            @(negedge clk);
            if (!rst_n) begin
                m_act = 1'b0;
                rel = 0;
                {e_en, e_sw, e_ov, e_done, e_busy} = 5'b0;
                e_addr = 0;
            end else begin
                rel    = cyc - m_c0;
                e_busy = m_act && rel >= 0 && rel <= done_rel(m_len);
                e_done = m_act && rel == done_rel(m_len);
                e_en   = m_act && rel >= 0 && rel < m_len;
                e_addr = (m_base + rel) % (1 << AW);
                k      = rel - SW_OFF;
                e_sw   = m_act && k >= 0 && k < m_len && swapbit(k, m_mode, m_stride);
                k      = rel - OV_OFF;
                e_ov   = m_act && k >= 0 && k < m_len;
            end
            check("rd_en", int'(rd_en), int'(e_en));
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
            check("switch_set", int'(switch_set), int'(e_sw));
            check("o_valid", int'(o_valid), int'(e_ov));
            if (e_en || !rst_n) check("rd_addr", int'(rd_addr), e_addr);
`ifdef TYPE_SWITCH_SEQ_CNT_EN
            if (e_done) check("swap_cnt", int'(swap_cnt), m_swaps);
`endif
            if (done) done_count++;
            if (m_act && rel >= 0 && rel < 64) begin
                obs_addr[rel] = int'(rd_addr);
                obs_en[rel]   = rd_en;
                obs_sw[rel]   = switch_set;
                obs_ov[rel]   = o_valid;
                obs_done[rel] = done;
                obs_busy[rel] = busy;
            end
            if (rst_n && start && !e_busy) begin
                m_act = 1'b1; m_c0 = cyc + 1;
                m_base = int'(base_addr); m_len = int'(len);
                m_mode = int'(swap_mode); m_stride = int'(stride_log);
                s = 0;
                for (int i = 0; i < m_len; i++) s += int'(swapbit(i, m_mode, m_stride));
                m_swaps = s;
                done_count = 0;
                for (int i = 0; i < 64; i++) begin
                    obs_addr[i] = 0; obs_en[i] = 0; obs_sw[i] = 0;
                    obs_ov[i] = 0; obs_done[i] = 0; obs_busy[i] = 0;
                end
            end
        end
    end

    // returns during cycle C0
    task automatic issue(input int b, input int l, input int m, input int s);
        @(posedge clk); #1;
        base_addr = b[AW-1:0]; len = l[AW:0]; swap_mode = m[1:0]; stride_log = s[SWW-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin : drv
        logic [7:0] pat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        issue(5, 4, 1, 0);
        repeat (12) @(posedge clk);
        for (int i = 0; i < 4; i++) check("A rd_addr literal", obs_addr[i], 5 + i);
        check("A rd_en end", int'(obs_en[4]), 0);
        check("A sw first", int'(obs_sw[2]), 1);
        check("A sw last", int'(obs_sw[5]), 1);
        check("A sw before", int'(obs_sw[1]), 0);
        check("A sw after", int'(obs_sw[6]), 0);
        check("A ov first", int'(obs_ov[4]), 1);
        check("A ov last", int'(obs_ov[7]), 1);
        check("A ov after", int'(obs_ov[8]), 0);
        check("A done C0+8", int'(obs_done[8]), 1);

        issue(100, 8, 2, 1);
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) pat[i] = obs_sw[2 + i];
        check("B mode10 pattern", int'(pat), int'(8'b11001100));

        issue(1022, 4, 0, 0);
        repeat (12) @(posedge clk);
        check("C wrap 0", obs_addr[0], 1022);
        check("C wrap 1", obs_addr[1], 1023);
        check("C wrap 2", obs_addr[2], 0);
        check("C wrap 3", obs_addr[3], 1);

        issue(0, 0, 1, 0);
        repeat (4) @(posedge clk);
        check("D done C0", int'(obs_done[0]), 1);
        check("D busy C0", int'(obs_busy[0]), 1);
        check("D busy C1", int'(obs_busy[1]), 0);
        check("D no rd_en", int'(obs_en[0]), 0);

        issue(50, 6, 1, 0);
        repeat (2) @(posedge clk); #1;
        base_addr = 10'd900; len = 11'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk); #1;
        base_addr = 10'd0; len = 11'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        check("E single done", done_count, 1);
        check("E latched addr", obs_addr[5], 55);
        check("E done C0+10", int'(obs_done[10]), 1);

        issue(7, 5, 2, 0);
        repeat (12) @(posedge clk);
        issue(7, 4, 2, 12);
        repeat (12) @(posedge clk);
        issue(7, 3, 3, 0);
        repeat (12) @(posedge clk);

        issue(200, 8, 1, 0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("G rst rd_en", int'(rd_en), 0);
        check("G rst busy", int'(busy), 0);
        check("G rst sw", int'(switch_set), 0);
        check("G rst valid", int'(o_valid), 0);
        check("G rst addr", int'(rd_addr), 0);
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("G no done", done_count, 0);

        issue(3, 1024, 2, 9);
        repeat (1040) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/type_switch_sequencer.md
Name: type_switch_sequencer

Overview:
- Upstream control stage for type_switch_module.
- On a start command it streams paired read requests to the two buffer RAM banks that feed i_port_0/i_port_1.
- It drives switch_set, delayed so the swap decision lines up with each element pair inside the switcher's 3-stage pipeline.
- It tracks the pairs through the pipeline and emits o_valid aligned with the switcher's outputs, plus a done pulse.

Parameters:
- ADDR_W, 10, width of bank read addresses and of the length field.
- RAM_RD_LAT, 1, cycles from rd_en to read data arriving at switcher i_port_0/i_port_1 (1..4).
- SW_LAT, 3, switcher input-to-output latency; the switcher samples switch_set SW_LAT-2 cycles after data arrives.
- STRIDE_W, 4, width of the stride_log field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first read address for both banks
- len  in  ADDR_W+1  number of element pairs (0..2^ADDR_W)
- swap_mode  in  2  00 none, 01 all, 10 alternate blocks, 11 treated as 00
- stride_log  in  STRIDE_W  block size log2 for mode 10
- rd_en  out  1  read enable, common to both banks
- rd_addr  out  ADDR_W  read address, common to both banks
- switch_set  out  1  to type_switch_module.switch_set
- o_valid  out  1  high while switcher outputs carry a valid pair
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state IDLE; rd_en, rd_addr, switch_set, o_valid, busy, done all 0; all pipeline tracking registers cleared.
- All outputs are registered.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: when start=1, latch base_addr, len, swap_mode, stride_log. Go to ISSUE if len>0, else go to FIN.
- Cycle numbering: C0 is the first cycle after start is sampled.
- ISSUE: rd_en=1 for cycles C0..C0+len-1; rd_addr = base_addr+k for element k.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - After element len-1 is issued, go to DRAIN.
- Swap bit for element k: mode 00/11 -> 0; mode 01 -> 1; mode 10 -> bit stride_log of the element index k (element counter ADDR_W+1 bits wide).
  - If stride_log > ADDR_W, the swap bit is 0.
- switch_set for element k is high or low during cycle C0+k+RAM_RD_LAT+(SW_LAT-2). Drive 0 in cycles that correspond to no element.
- Implement the alignment as a valid/swap shift register fed at issue time, with depth RAM_RD_LAT+SW_LAT.
- o_valid is high during cycle C0+k+RAM_RD_LAT+SW_LAT for every k, i.e. one contiguous burst of len cycles.
- DRAIN: wait until the shift register is empty, then go to FIN.
- FIN: done=1 for exactly one cycle, then return to IDLE. For len=0, done is high at C0 and o_valid never rises.
- busy is high from C0 through the done cycle inclusive; it is low in IDLE.
- start while busy is ignored; no queuing, and latched fields are unchanged.
- start in the same cycle as done is also ignored; the next command is accepted when busy=0.
- There is no stall input: the switcher cannot stall, so issue runs at one pair per cycle with no gaps.
- len=2^ADDR_W is legal: it covers the whole bank and rd_addr wraps back to base_addr-1 at the end.
- Reset mid-command: immediately return to IDLE with all outputs 0. In-flight tracking is discarded and no done is emitted.

Optional Feature:
- TYPE_SWITCH_SEQ_CNT_EN defined: adds output swap_cnt (ADDR_W+1 bits).
  - Cleared at start acceptance.
  - Incremented each cycle that switch_set=1.
  - Holds its final value after done until the next accepted start; reset value 0.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then idle for 10 cycles -> all outputs 0, no rd_en.
- RAM_RD_LAT=1, base_addr=5, len=4, mode 01:
  - rd_en high C0..C0+3 with rd_addr 5,6,7,8.
  - switch_set high C0+2..C0+5.
  - o_valid high C0+4..C0+7.
  - done at C0+8.
  - With CNT_EN, swap_cnt=4.
- Mode 10, stride_log=1, len=8 -> switch_set pattern 0,0,1,1,0,0,1,1 starting at C0+2; swap_cnt=4.
- base_addr=1022, len=4, ADDR_W=10 -> rd_addr 1022,1023,0,1.
- len=0 -> done at C0, busy for exactly 1 cycle, no rd_en/o_valid.
- Extra start pulse at C0+2 of a len=6 run -> ignored, single done pulse. Separately, assert rst_n=0 mid-ISSUE -> outputs 0 immediately, no done, FSM in IDLE.
